// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_pkg
//  Description : Shared definitions for the instruction fetch queue:
//                default depth and width, queue entry layout and the
//                architectural reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifq_pkg;

    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_XLEN  = 32;

    localparam logic [IFQ_XLEN-1:0] RESET_PC = 32'h8000_0000;

    // One queue slot: fetch address, returned instruction, and whether the
    // instruction has come back from memory yet.
    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
        logic                filled;
    } ifq_entry_t;

endpackage : ifq_pkg
`default_nettype wire

// File: rtl/ifq_storage.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_storage
//  Description : DEPTH-entry register array for the fetch queue.
//                Write port A (alloc): stores the PC, clears filled.
//                Write port B (fill) : stores the instruction, sets filled.
//                Read port (head)    : pc, instr, filled of the head slot.
//                clear_head / clear_all drop filled bits on dequeue / flush.
//  Ports       : clk, rst, alloc_*, fill_*, clear_head, clear_all,
//                head_idx, head_pc, head_instr, head_filled
//  Revision    : 1.0 - initial release
// ============================================================================
module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill_en,
    input  logic [$clog2(DEPTH)-1:0] fill_idx,
    input  logic [XLEN-1:0]          fill_instr,
    input  logic                     clear_head,
    input  logic                     clear_all,
    input  logic [$clog2(DEPTH)-1:0] head_idx,
    output logic [XLEN-1:0]          head_pc,
    output logic [XLEN-1:0]          head_instr,
    output logic                     head_filled
);

    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [XLEN-1:0]  r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;

    // Payload needs no reset: a slot is only visible once its filled bit is set.
    always_ff @(posedge clk) begin
        if (alloc_en) r_pc[alloc_idx]   <= alloc_pc;
        if (fill_en)  r_instr[fill_idx] <= fill_instr;
    end

    // Alloc, fill and head never target the same slot in one cycle, so the
    // order of these writes only matters for clear_all.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            r_filled <= '0;
        end else begin
            if (alloc_en)   r_filled[alloc_idx] <= 1'b0;
            if (clear_head) r_filled[head_idx]  <= 1'b0;
            if (fill_en)    r_filled[fill_idx]  <= 1'b1;
        end
    end

    assign head_pc     = r_pc[head_idx];
    assign head_instr  = r_instr[head_idx];
    assign head_filled = r_filled[head_idx];

endmodule : ifq_storage
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_queue
//  Description : In-order instruction fetch queue between the PC register,
//                instruction memory and decode. A slot is reserved when the
//                request issues; responses fill slots in order; decode
//                drains filled slots from the head. A flush discards all
//                slots and remembers how many in-flight responses to drop.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                pc_in, pc_valid, fetch_stall  - PC register side
//                flush                         - redirect
//                imem_req_*, imem_resp_*       - instruction memory
//                id_valid/ready, id_instr/pc   - decode side
//                resp_err                      - sticky unexpected response
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int XLEN  = IFQ_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            fetch_stall,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            resp_err
);

    localparam int              c_PW      = $clog2(DEPTH);
    localparam int              c_CW      = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
    localparam logic [c_CW:0]   c_ONE_X   = (c_CW + 1)'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

    logic [c_PW-1:0] r_alloc_ptr, r_fill_ptr, r_head_ptr;
    logic [c_CW-1:0] r_count;      // occupied slots, issued or filled
    logic [c_CW-1:0] r_pend;       // issued slots still awaiting a response
    logic [c_CW-1:0] r_drop_cnt;   // responses owed to flushed requests
    logic            r_resp_err;

    logic            w_fire, w_deq, w_drop_idle, w_resp_ok, w_resp_bad;
    logic            w_head_filled;
    logic [c_CW:0]   w_drop_sum;
    logic [c_CW-1:0] w_drop_flush;

    // Occupancy is the registered count: a same-cycle dequeue frees nothing.
    assign imem_req_valid = pc_valid & (r_count < c_DEPTH) & ~flush & ~rst;
    assign imem_req_addr  = pc_in;
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign fetch_stall    = ~rst & ((pc_valid & ~w_fire) | flush);

    assign w_drop_idle = (r_drop_cnt == '0);
    assign w_resp_ok   = imem_resp_valid & w_drop_idle & (r_pend != '0) & ~flush;
    assign w_resp_bad  = imem_resp_valid & w_drop_idle & (r_pend == '0);

    assign id_valid = ~rst & w_head_filled & (r_count != '0);
    assign w_deq    = id_valid & id_ready & ~flush;

    // Drop count after a flush: everything owed so far plus every slot still
    // waiting, less a response that lands in the flush cycle itself.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, r_pend};
        if (imem_resp_valid && (w_drop_sum != '0)) begin
            w_drop_sum = w_drop_sum - c_ONE_X;
        end
        if (w_drop_sum > {1'b0, c_DEPTH}) begin
            w_drop_flush = c_DEPTH;
        end else begin
            w_drop_flush = w_drop_sum[c_CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            r_drop_cnt  <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_resp_bad) r_resp_err <= 1'b1;

            if (flush) begin
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_head_ptr  <= '0;
                r_count     <= '0;
                r_pend      <= '0;
                r_drop_cnt  <= w_drop_flush;
            end else begin
                if (w_fire)    r_alloc_ptr <= r_alloc_ptr + c_PTR_ONE;
                if (w_resp_ok) r_fill_ptr  <= r_fill_ptr + c_PTR_ONE;
                if (w_deq)     r_head_ptr  <= r_head_ptr + c_PTR_ONE;

                if (imem_resp_valid && !w_drop_idle) begin
                    r_drop_cnt <= r_drop_cnt - c_ONE;
                end

                case ({w_fire, w_deq})
                    2'b10:   r_count <= r_count + c_ONE;
                    2'b01:   r_count <= r_count - c_ONE;
                    default: r_count <= r_count;
                endcase

                case ({w_fire, w_resp_ok})
                    2'b10:   r_pend <= r_pend + c_ONE;
                    2'b01:   r_pend <= r_pend - c_ONE;
                    default: r_pend <= r_pend;
                endcase
            end
        end
    end

    assign resp_err = r_resp_err;

    ifq_storage #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_storage (
        .clk         (clk),
        .rst         (rst),
        .alloc_en    (w_fire),
        .alloc_idx   (r_alloc_ptr),
        .alloc_pc    (pc_in),
        .fill_en     (w_resp_ok),
        .fill_idx    (r_fill_ptr),
        .fill_instr  (imem_resp_data),
        .clear_head  (w_deq),
        .clear_all   (flush),
        .head_idx    (r_head_ptr),
        .head_pc     (id_pc),
        .head_instr  (id_instr),
        .head_filled (w_head_filled)
    );

endmodule : ifetch_queue
`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, power of two, 2..16; number of queue entries; issued but unreturned requests count as occupied entries.
REQ-002 Parameter XLEN, default 32, address and instruction width.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pc_in  in  XLEN  fetch address from the PC register.
REQ-007 pc_valid  in  1  pc_in requests a fetch this cycle.
REQ-008 fetch_stall  out  1  PC register holds its value this cycle.
REQ-009 flush  in  1  redirect (branch, mispredict, CSR trap); discards all queued and in-flight fetches.
REQ-010 imem_req_valid / imem_req_ready  out / in  1 / 1  instruction memory request handshake.
REQ-011 imem_req_addr  out  XLEN  request address, equal to pc_in.
REQ-012 imem_resp_valid  in  1  one in-order response word is present.
REQ-013 imem_resp_data  in  XLEN  response instruction.
REQ-014 id_valid / id_ready  out / in  1 / 1  decode-stage handshake.
REQ-015 id_instr, id_pc  out  XLEN each  head instruction and its fetch address.
REQ-016 resp_err  out  1  sticky flag; set by an unexpected response.

Function
REQ-017 Entry fields: pc, instr, filled bit. Pointers: alloc_ptr, fill_ptr, head_ptr. Registered occupancy count ranges 0..DEPTH.
REQ-018 imem_req_valid = pc_valid & (count < DEPTH) & ~flush & ~rst. Occupancy is the registered value; a dequeue in the same cycle does not free a slot.
REQ-019 Issue fires when imem_req_valid & imem_req_ready. On fire: write pc_in into entry[alloc_ptr], clear its filled bit, advance alloc_ptr modulo DEPTH, count+1.
REQ-020 fetch_stall = pc_valid & ~fire; fetch_stall is also asserted during a flush cycle.
REQ-021 Response accepted when imem_resp_valid & drop_cnt==0 & an allocated, unfilled entry exists. On acceptance: write instr into entry[fill_ptr], set its filled bit, advance fill_ptr.
REQ-022 Minimum response-to-id_valid latency is 1 cycle; there is no bypass.
REQ-023 id_valid = filled[head_ptr] & count>0; id_instr and id_pc come combinationally from entry[head_ptr].
REQ-024 Dequeue fires when id_valid & id_ready & ~flush. On dequeue: clear filled, advance head_ptr, count-1. Issue and dequeue in the same cycle leave count unchanged.
REQ-025 Flush, at the next edge: clear all filled bits; set count=0 and all pointers equal; drop_cnt = drop_cnt + (number of issued, unfilled entries).
REQ-026 If flush coincides with a response, that response is discarded and subtracted from the new drop_cnt.
REQ-027 While drop_cnt>0, each imem_resp_valid is discarded and decrements drop_cnt; new requests may still issue.
REQ-028 A response arriving with drop_cnt==0 and no unfilled allocated entry sets resp_err and is otherwise ignored.
REQ-029 When count==DEPTH: no issue, fetch_stall=1 if pc_valid.
REQ-030 When empty: id_valid=0.
REQ-031 Pointer wrap DEPTH-1 -> 0.
REQ-032 drop_cnt width is clog2(DEPTH)+1, saturating; it never exceeds DEPTH.

Reset
REQ-033 rst at any time, including mid-flight, clears all pointers, count, drop_cnt, filled bits, and resp_err on the next edge.
REQ-034 During rst: imem_req_valid=0, id_valid=0, fetch_stall=0. id_instr and id_pc are don't-care while id_valid=0.
REQ-035 Responses outstanding across reset are the memory's responsibility; the memory is reset in the same cycle.

Structure
REQ-036 Shared package ifq_pkg holds:
- IFQ_DEPTH default
- entry struct {pc, instr, filled}
- RESET_PC 32'h8000_0000 for bench use
REQ-037 One sub-module, ifq_storage: DEPTH-entry register array with one write port for alloc, one for fill, and one read port at head. All control logic stays in ifetch_queue.

Verification
REQ-038 Streaming: pc_valid=1 with PCs 0x80000000, +4, +8; imem ready, 1-cycle response, id_ready=1. Required: id_pc sequence 0x80000000, 0x80000004, 0x80000008 with matching instructions; fetch_stall=0 after the first issue.
REQ-039 Full: id_ready=0, DEPTH=4, 4 issues. Required: 5th cycle imem_req_valid=0 and fetch_stall=1. One id_ready pulse gives exactly one further issue, on the following cycle.
REQ-040 Flush with 2 in flight: issue 0x80000010 and 0x80000014, then flush before any response, then issue 0x80000100. Required: the first 2 responses are dropped; the next id_pc is 0x80000100.
REQ-041 Flush coincident with response: 1 entry in flight, flush and response in the same cycle. Required: drop_cnt=0 after the edge, id_valid=0, resp_err=0.
REQ-042 Spurious response: imem_resp_valid with empty queue and drop_cnt=0. Required: resp_err=1 next cycle, stays 1 until rst.
REQ-043 Reset mid-operation: 3 entries queued, rst=1 for 1 cycle. Required: id_valid=0, count=0, resp_err=0; next issue lands in entry 0.
